// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared encoder definitions: state encoding, SRAM plane map, BT.601 coefficients.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [3:0] {
    S_ENC_IDLE, S_ENC_RD0, S_ENC_RD1, S_ENC_RD2, S_ENC_CAP1,
    S_ENC_Y0, S_ENC_Y1, S_ENC_U, S_ENC_V,
    S_ENC_WR_Y, S_ENC_WR_U, S_ENC_WR_V, S_ENC_DONE
  } enc_state_e;

  typedef enum logic [1:0] { CSC_Y, CSC_U, CSC_V } csc_sel_e;

  localparam logic [17:0] Y_BASE   = 18'd0;
  localparam logic [17:0] U_BASE   = 18'd38400;
  localparam logic [17:0] V_BASE   = 18'd57600;
  localparam logic [17:0] RGB_BASE = 18'd146944;
  localparam int          NUM_PAIRS_FRAME = 38400;

  // Luma works on single pixels, chroma on 9-bit pair sums (hence one more shift bit).
  localparam logic signed [31:0] K_YR =  32'sd16843;
  localparam logic signed [31:0] K_YG =  32'sd33030;
  localparam logic signed [31:0] K_YB =  32'sd6423;
  localparam logic signed [31:0] K_UR = -32'sd9699;
  localparam logic signed [31:0] K_UG = -32'sd19071;
  localparam logic signed [31:0] K_UB =  32'sd28770;
  localparam logic signed [31:0] K_VR =  32'sd28770;
  localparam logic signed [31:0] K_VG = -32'sd24117;
  localparam logic signed [31:0] K_VB = -32'sd4653;
  localparam logic signed [31:0] RND_Y  = 32'sd32768;
  localparam logic signed [31:0] RND_UV = 32'sd65536;
  localparam logic signed [31:0] OFS_Y  = 32'sd16;
  localparam logic signed [31:0] OFS_UV = 32'sd128;

  // Word address of the first RGB word of pair k (3k offset, shift-and-add).
  function automatic logic [17:0] rgb_addr(input logic [15:0] k);
    return RGB_BASE + {2'b00, k} + {1'b0, k, 1'b0};
  endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_csc_mac3.sv
// Three-multiplier colour-space MAC: coefficient set chosen by sel, rounded, shifted, clipped.
module csc_mac3
  import rgb_to_yuv_encoder_pkg::*;
(
  input  csc_sel_e   sel,
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic [8:0] c,
  output logic [7:0] q
);

  logic signed [31:0] ka, kb, kc, pa, pb, pc, acc, res;

  // Pick coefficients, multiply-accumulate, then round/shift/offset and saturate to 8 bits.
  always_comb begin
    ka = K_YR; kb = K_YG; kc = K_YB;
    case (sel)
      CSC_U:   begin ka = K_UR; kb = K_UG; kc = K_UB; end
      CSC_V:   begin ka = K_VR; kb = K_VG; kc = K_VB; end
      default: ;
    endcase
    pa  = ka * $signed({23'd0, a});
    pb  = kb * $signed({23'd0, b});
    pc  = kc * $signed({23'd0, c});
    acc = pa + pb + pc + ((sel == CSC_Y) ? RND_Y : RND_UV);
    res = (sel == CSC_Y) ? (acc >>> 16) + OFS_Y : (acc >>> 17) + OFS_UV;
    if (res < 0)        q = 8'd0;
    else if (res > 255) q = 8'd255;
    else                q = res[7:0];
  end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Reads interleaved RGB pairs from SRAM, writes planar Y and 2:1 decimated U/V back.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_FRAME
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  enc_state_e  state;
  logic [15:0] k;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [7:0]  y0, y1, u, v, u_hold, v_hold;
  csc_sel_e    sel;
  logic [8:0]  op_a, op_b, op_c;
  logic [7:0]  mac_q;

  // Feed the single MAC: one pixel for luma, pair sums for chroma.
  always_comb begin
    sel  = CSC_Y;
    op_a = {1'b0, r0};
    op_b = {1'b0, g0};
    op_c = {1'b0, b0};
    case (state)
      S_ENC_Y1: begin op_a = {1'b0, r1}; op_b = {1'b0, g1}; op_c = {1'b0, b1}; end
      S_ENC_U, S_ENC_V: begin
        sel  = (state == S_ENC_U) ? CSC_U : CSC_V;
        op_a = {1'b0, r0} + {1'b0, r1};
        op_b = {1'b0, g0} + {1'b0, g1};
        op_c = {1'b0, b0} + {1'b0, b1};
      end
      default: ;
    endcase
  end

  csc_mac3 u_mac (.sel(sel), .a(op_a), .b(op_b), .c(op_c), .q(mac_q));

  // Pair sequencer; all SRAM port values are registered on entry to the state that shows them.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_ENC_IDLE;
      k <= '0;
      {r0, g0, b0, r1, g1, b1} <= '0;
      {y0, y1, u, v, u_hold, v_hold} <= '0;
      SRAM_address <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n <= 1'b1;
      Done <= 1'b0;
    end else begin
      SRAM_we_n <= 1'b1;
      Done <= 1'b0;
      case (state)
        S_ENC_IDLE: if (Enable) begin
          k <= '0;
          SRAM_address <= RGB_BASE;
          state <= S_ENC_RD0;
        end
        S_ENC_RD0: begin SRAM_address <= SRAM_address + 18'd1; state <= S_ENC_RD1; end
        S_ENC_RD1: begin SRAM_address <= SRAM_address + 18'd1; state <= S_ENC_RD2; end
        S_ENC_RD2: begin {r0, g0} <= SRAM_read_data; state <= S_ENC_CAP1; end
        S_ENC_CAP1: begin {b0, r1} <= SRAM_read_data; state <= S_ENC_Y0; end
        S_ENC_Y0: begin {g1, b1} <= SRAM_read_data; y0 <= mac_q; state <= S_ENC_Y1; end
        S_ENC_Y1: begin y1 <= mac_q; state <= S_ENC_U; end
        S_ENC_U:  begin u <= mac_q; state <= S_ENC_V; end
        S_ENC_V: begin
          v <= mac_q;
          SRAM_address <= Y_BASE + 18'(k);
          SRAM_write_data <= {y0, y1};
          SRAM_we_n <= 1'b0;
          state <= S_ENC_WR_Y;
        end
        S_ENC_WR_Y: begin
          if (!k[0]) begin
            // Even pair: park chroma until its odd partner arrives.
            u_hold <= u;
            v_hold <= v;
            k <= k + 16'd1;
            SRAM_address <= rgb_addr(k + 16'd1);
            state <= S_ENC_RD0;
          end else begin
            SRAM_address <= U_BASE + 18'(k >> 1);
            SRAM_write_data <= {u_hold, u};
            SRAM_we_n <= 1'b0;
            state <= S_ENC_WR_U;
          end
        end
        S_ENC_WR_U: begin
          SRAM_address <= V_BASE + 18'(k >> 1);
          SRAM_write_data <= {v_hold, v};
          SRAM_we_n <= 1'b0;
          state <= S_ENC_WR_V;
        end
        S_ENC_WR_V: begin
          if (k == 16'(NUM_PAIRS - 1)) begin
            Done <= 1'b1;
            state <= S_ENC_DONE;
          end else begin
            k <= k + 16'd1;
            SRAM_address <= rgb_addr(k + 16'd1);
            state <= S_ENC_RD0;
          end
        end
        S_ENC_DONE: state <= S_ENC_IDLE;
        default: state <= S_ENC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Scoreboard bench: reference YUV model fills an expected-write queue, SRAM write port drains it.
module tb_rgb_to_yuv_encoder;

  localparam int NP    = 128;
  localparam int TOTAL = NP * 10;
  localparam int RGB0  = 146944;
  localparam int YB = 0, UB = 38400, VB = 57600;

  typedef struct { int addr; int data; int off; } exp_t;

  logic        Clock = 0, Resetn = 0, Enable = 0;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, Done;

  logic [15:0] img [0:NP*3-1];
  logic [15:0] rd_d1;
  exp_t        q[$];
  int          n_pass = 0, n_chk = 0;

  rgb_to_yuv_encoder #(.NUM_PAIRS(NP)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
    .SRAM_read_data(SRAM_read_data), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // SRAM read port: data for an address cycle appears two cycles later.
  always @(posedge Clock) begin
    if (int'(SRAM_address) >= RGB0 && int'(SRAM_address) < RGB0 + NP*3)
      rd_d1 <= img[int'(SRAM_address) - RGB0];
    else
      rd_d1 <= 16'hDEAD;
    SRAM_read_data <= rd_d1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
  endtask

  function automatic int clip(input int x);
    return (x < 0) ? 0 : (x > 255) ? 255 : x;
  endfunction
  function automatic int ref_y(input int r, input int g, input int b);
    return clip(((16843*r + 33030*g + 6423*b + 32768) >>> 16) + 16);
  endfunction
  function automatic int ref_u(input int r, input int g, input int b);
    return clip(((-9699*r - 19071*g + 28770*b + 65536) >>> 17) + 128);
  endfunction
  function automatic int ref_v(input int r, input int g, input int b);
    return clip(((28770*r - 24117*g - 4653*b + 65536) >>> 17) + 128);
  endfunction

  // Fill the image for a pattern and queue every expected write with its cycle offset.
  task automatic build(input int pat);
    int px[6], st, uh, vh, uk, vk;
    exp_t e;
    q.delete();
    uh = 0; vh = 0;
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < 6; i++) begin
        case (pat)
          0: px[i] = 0;
          1: px[i] = 255;
          2: px[i] = (i == 0 || i == 3) ? 255 : 0;
          3: px[i] = (k % 2) ? 255 : 0;
          default: px[i] = int'($urandom_range(0, 255));
        endcase
      end
      img[3*k]   = 16'((px[0] << 8) | px[1]);
      img[3*k+1] = 16'((px[2] << 8) | px[3]);
      img[3*k+2] = 16'((px[4] << 8) | px[5]);
      st = (k / 2) * 20 + (k % 2) * 9;
      e.addr = YB + k;
      e.data = (ref_y(px[0], px[1], px[2]) << 8) | ref_y(px[3], px[4], px[5]);
      e.off  = st + 8;
      q.push_back(e);
      uk = ref_u(px[0] + px[3], px[1] + px[4], px[2] + px[5]);
      vk = ref_v(px[0] + px[3], px[1] + px[4], px[2] + px[5]);
      if (k % 2 == 0) begin uh = uk; vh = vk; end
      else begin
        e.addr = UB + k/2; e.data = (uh << 8) | uk; e.off = st + 9;  q.push_back(e);
        e.addr = VB + k/2; e.data = (vh << 8) | vk; e.off = st + 10; q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, int'(SRAM_address), 0);
    chk({tag, "_wdata"}, int'(SRAM_write_data), 0);
    chk({tag, "_we_n"}, int'(SRAM_we_n), 1);
    chk({tag, "_done"}, int'(Done), 0);
  endtask

  // One frame, sampled on negedges; rst_pair >= 0 pulls Resetn at the start of that pair.
  task automatic run_frame(input string name, input int pat, input int rst_pair);
    int t, viol, dones, done_off;
    exp_t e;
    build(pat);
    viol = 0; dones = 0; done_off = -1;
    @(negedge Clock) Enable = 1;
    @(negedge Clock) Enable = 0;
    chk({name, "_start_addr"}, int'(SRAM_address), RGB0);
    for (t = 0; t < TOTAL + 3; t++) begin
      if (rst_pair >= 0 && t == (rst_pair / 2) * 20 + (rst_pair % 2) * 9) begin
        #2 Resetn = 0;
        #1 check_reset_outputs({name, "_async_rst"});
        repeat (3) @(negedge Clock);
        Resetn = 1;
        q.delete();
        return;
      end
      if (!SRAM_we_n) begin
        if (int'(SRAM_address) > 76799) viol++;
        if (q.size() == 0) chk({name, "_unexpected_write"}, int'(SRAM_address), -1);
        else begin
          e = q.pop_front();
          chk({name, "_wr_addr"}, int'(SRAM_address), e.addr);
          chk({name, "_wr_data"}, int'(SRAM_write_data), e.data);
          chk({name, "_wr_cycle"}, t, e.off);
        end
      end else if (t < TOTAL && (int'(SRAM_address) < RGB0 || int'(SRAM_address) > 262143)) viol++;
      if (Done) begin dones++; done_off = t; end
      @(negedge Clock);
    end
    chk({name, "_addr_bounds"}, viol, 0);
    chk({name, "_done_pulses"}, dones, 1);
    chk({name, "_done_cycle"}, done_off, TOTAL);
    chk({name, "_writes_left"}, q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    Resetn = 1;
    @(negedge Clock);
    chk("idle_no_enable_we_n", int'(SRAM_we_n), 1);
    run_frame("black", 0, -1);
    run_frame("white", 1, -1);
    run_frame("red", 2, -1);
    run_frame("alt", 3, -1);
    run_frame("random", 4, -1);
    run_frame("alt_rst", 3, 100);
    run_frame("after_rst", 4, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rgb_to_yuv_encoder.md
# rgb_to_yuv_encoder

Colour-space encoder that reads a 320×240 interleaved RGB image from external SRAM, converts each pixel to YCbCr (BT.601, fixed point), decimates U/V 2:1 horizontally, and writes planar Y, U, V back to SRAM. It is the inverse of the Milestone‑1 decompressor path: it produces the exact memory layout that path consumes, and serves as the test-image generator and round-trip checker. It shares the single SRAM port with the other milestone blocks under the top-level arbiter.

## Interface
- Y_BASE, 18'd0: Y plane base address.
- U_BASE, 18'd38400: U plane base address.
- V_BASE, 18'd57600: V plane base address.
- RGB_BASE, 18'd146944: RGB image base address.
- NUM_PAIRS, 38400: pixel pairs per frame; must be even.

- Clock  in  1  system clock.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  level start request; sampled only in S_ENC_IDLE.
- SRAM_read_data  in  16  read data, valid 2 cycles after its address cycle.
- SRAM_address  out  18  registered; reset 0.
- SRAM_write_data  out  16  registered; reset 0.
- SRAM_we_n  out  1  registered, active-low write enable; reset 1.
- Done  out  1  registered one-cycle pulse at frame end; reset 0.

## Operation
- RGB layout per pair k: word 3k = {R0,G0}, 3k+1 = {B0,R1}, 3k+2 = {G1,B1}; the first-named byte is [15:8].
- Outputs per pair: Y word Y_BASE+k = {Y0,Y1}. Per pair of pairs (k odd), one U word U_BASE+(k>>1) = {U_(k-1),U_k} and one V word at V_BASE+(k>>1).
- Pixel arithmetic, all signed 32-bit, with >>> as arithmetic shift:
  - Y = ((16843R + 33030G + 6423B + 32768) >>> 16) + 16.
  - Pair chroma uses sums Rs=R0+R1, Gs, Bs (9-bit).
  - U = ((−9699Rs − 19071Gs + 28770Bs + 65536) >>> 17) + 128.
  - V = ((28770Rs − 24117Gs − 4653Bs + 65536) >>> 17) + 128.
  - Each result is clipped to [0,255].
- Exactly three multipliers. Coefficient set is selected by state.
- For even k, U_k and V_k are held in U_hold/V_hold. For odd k, they are packed and written.
- States: S_ENC_IDLE, S_ENC_RD0, S_ENC_RD1, S_ENC_RD2, S_ENC_CAP1, S_ENC_Y0, S_ENC_Y1, S_ENC_U, S_ENC_V, S_ENC_WR_Y, S_ENC_WR_U, S_ENC_WR_V, S_ENC_DONE.
- Transitions:
  - IDLE→RD0 when Enable=1.
  - Pair sequence runs RD0 through WR_Y.
  - WR_Y→RD0 if k even. Otherwise WR_Y→WR_U→WR_V.
  - WR_V→RD0, or →DONE after the last pair.
  - DONE→IDLE.
- Enable during a frame is ignored. Enable held high at DONE→IDLE starts a new frame.

## Timing
- Per-pair cycle map (port values are shown in each cycle):
  - c0 RD0: addr RGB_BASE+3k, we_n=1.
  - c1 RD1: addr +1.
  - c2 RD2: addr +2; capture {R0,G0} at end of cycle.
  - c3 CAP1: capture {B0,R1}.
  - c4 Y0: capture {G1,B1}; register Y0.
  - c5 Y1: register Y1.
  - c6 U: register U.
  - c7 V: register V.
  - c8 WR_Y: addr Y_BASE+k, data {Y0,Y1}, we_n=0.
  - c9 WR_U: U word, we_n=0 (odd k only).
  - c10 WR_V: V word, we_n=0 (odd k only).
- Pair cost is 9 cycles (even k) or 11 cycles (odd k). A frame is 384000 cycles from the first RD0.
- we_n returns to 1 in the cycle after any write state.
- Done is high for exactly the one cycle in S_ENC_DONE, which follows the last WR_V at address V_BASE+19199 = 76799.
- Reset mid-frame: all outputs return to reset values immediately and the state returns to IDLE. There is no resume; the next Enable restarts at pair 0.

## Structure
- Shared package (milestone defs, alongside define_state.h):
  - the encoder state enum;
  - base-address constants;
  - the nine colour coefficients and the rounding constants.
- Sub-module csc_mac3: combinational block with three signed 32-bit multiplies plus sum, round and shift. It takes a select (Y/U/V) and three operands and returns the clipped 8-bit result. One instance is used.

## Test plan
- All pixels black (all RGB words 0) -> every Y word 16'h1010, every U/V word 16'h8080, Done after 384000 cycles.
- All pixels white (16'hFFFF) -> Y words 16'hEBEB, U/V words 16'h8080.
- Pure red frame (words 16'hFF00, 16'h00FF, 16'h0000) -> Y words 16'h5252, U words 16'h5A5A, V words 16'hF0F0.
- Alternating pairs (pair0 black, pair1 white) -> Y_BASE = 16'h1010, Y_BASE+1 = 16'hEBEB, U_BASE = 16'h8080. Check the 11-cycle pair timing and we_n pulses at c8–c10.
- Address bounds -> no write outside [0,76799], no read outside [146944,262143]; last write address 76799 followed by a single-cycle Done.
- Resetn asserted at pair 100 -> outputs go to reset values asynchronously; re-Enable restarts reads at address 146944.
